// File: rtl/branch_resolve_unit.sv
// Branch resolution for the 16-bit pipeline: flag register, EX flag bypass,
// zero-latency condition evaluation, PC redirect/flush and branch statistics.
module branch_resolve_unit #(
    parameter int XLEN  = 16,
    parameter int IMM_W = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_set_z,
    input  logic             ex_set_nv,
    input  logic             ex_zero,
    input  logic             ex_neg,
    input  logic             ex_ovfl,
    input  logic             id_br_valid,
    input  logic             id_stall,
    input  logic             id_br_reg,
    input  logic [2:0]       id_cond,
    input  logic [XLEN-1:0]  id_pc_plus2,
    input  logic [IMM_W-1:0] id_imm,
    input  logic [XLEN-1:0]  id_reg_target,
    output logic             br_taken,
    output logic [XLEN-1:0]  br_target,
    output logic             flush,
    output logic [2:0]       flags_q,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] nottaken_cnt
);

    typedef enum logic {
        IDLE   = 1'b0,
        SQUASH = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        C_NEQ  = 3'b000,
        C_EQ   = 3'b001,
        C_GT   = 3'b010,
        C_LT   = 3'b011,
        C_GTE  = 3'b100,
        C_LTE  = 3'b101,
        C_OVFL = 3'b110,
        C_UNC  = 3'b111
    } cond_e;

    localparam int FZ = 2;
    localparam int FN = 1;
    localparam int FV = 0;

    state_e           state_q;
    state_e           state_d;
    logic [2:0]       flags_d;
    logic [CNT_W-1:0] taken_cnt_q;
    logic [CNT_W-1:0] taken_cnt_d;
    logic [CNT_W-1:0] nottaken_cnt_q;
    logic [CNT_W-1:0] nottaken_cnt_d;

    logic             ex_commit;
    logic             z_eff;
    logic             n_eff;
    logic             v_eff;
    logic             cond_true;
    logic             resolve;
    logic [XLEN-1:0]  imm_off;
    logic [XLEN-1:0]  rel_target;

    // Flag commit: only selected bits update, and only on an unstalled EX slot.
    assign ex_commit = ex_valid & ~ex_stall;

    always_comb begin
        flags_d = flags_q;
        if (ex_commit && ex_set_z) begin
            flags_d[FZ] = ex_zero;
        end
        if (ex_commit && ex_set_nv) begin
            flags_d[FN] = ex_neg;
            flags_d[FV] = ex_ovfl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Bypass ignores ex_stall: a stalled EX still presents its final flags.
    assign z_eff = (ex_valid & ex_set_z)  ? ex_zero : flags_q[FZ];
    assign n_eff = (ex_valid & ex_set_nv) ? ex_neg  : flags_q[FN];
    assign v_eff = (ex_valid & ex_set_nv) ? ex_ovfl : flags_q[FV];

    always_comb begin
        cond_true = 1'b0;
        unique case (cond_e'(id_cond))
            C_NEQ:   cond_true = ~z_eff;
            C_EQ:    cond_true = z_eff;
            C_GT:    cond_true = ~z_eff & ~n_eff;
            C_LT:    cond_true = n_eff;
            C_GTE:   cond_true = z_eff | ~n_eff;
            C_LTE:   cond_true = z_eff | n_eff;
            C_OVFL:  cond_true = v_eff;
            C_UNC:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    // The slot after a redirect is wrong-path, so SQUASH blocks resolution.
    assign resolve = id_br_valid & ~id_stall & (state_q == IDLE) & ~rst;

    assign imm_off = {{(XLEN-IMM_W-1){id_imm[IMM_W-1]}}, id_imm, 1'b0};
    assign rel_target = id_pc_plus2 + imm_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (resolve && cond_true) begin
                    state_d = SQUASH;
                end
            end
            SQUASH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        br_taken  = 1'b0;
        br_target = '0;
        unique case (state_q)
            IDLE: begin
                br_taken = resolve & cond_true;
                if (br_taken) begin
                    br_target = id_br_reg ? id_reg_target : rel_target;
                end
            end
            SQUASH: begin
                br_taken  = 1'b0;
                br_target = '0;
            end
            default: begin
                br_taken  = 1'b0;
                br_target = '0;
            end
        endcase
    end

    assign flush = br_taken;

    // Statistics saturate at all-ones instead of wrapping.
    always_comb begin
        taken_cnt_d    = taken_cnt_q;
        nottaken_cnt_d = nottaken_cnt_q;
        if (resolve && cond_true && (taken_cnt_q != '1)) begin
            taken_cnt_d = taken_cnt_q + 1'b1;
        end
        if (resolve && !cond_true && (nottaken_cnt_q != '1)) begin
            nottaken_cnt_d = nottaken_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_q    <= '0;
            nottaken_cnt_q <= '0;
        end else begin
            taken_cnt_q    <= taken_cnt_d;
            nottaken_cnt_q <= nottaken_cnt_d;
        end
    end

    assign taken_cnt    = taken_cnt_q;
    assign nottaken_cnt = nottaken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_stall, ex_set_z, ex_set_nv;
    logic        ex_zero, ex_neg, ex_ovfl;
    logic        id_br_valid, id_stall, id_br_reg;
    logic [2:0]  id_cond;
    logic [15:0] id_pc_plus2;
    logic [8:0]  id_imm;
    logic [15:0] id_reg_target;
    logic        br_taken;
    logic [15:0] br_target;
    logic        flush;
    logic [2:0]  flags_q;
    logic [15:0] taken_cnt;
    logic [15:0] nottaken_cnt;

    branch_resolve_unit #(.XLEN(16), .IMM_W(9), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_stall      (ex_stall),
        .ex_set_z      (ex_set_z),
        .ex_set_nv     (ex_set_nv),
        .ex_zero       (ex_zero),
        .ex_neg        (ex_neg),
        .ex_ovfl       (ex_ovfl),
        .id_br_valid   (id_br_valid),
        .id_stall      (id_stall),
        .id_br_reg     (id_br_reg),
        .id_cond       (id_cond),
        .id_pc_plus2   (id_pc_plus2),
        .id_imm        (id_imm),
        .id_reg_target (id_reg_target),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .flush         (flush),
        .flags_q       (flags_q),
        .taken_cnt     (taken_cnt),
        .nottaken_cnt  (nottaken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          chk_br;
        logic        br;
        logic [15:0] tgt;
        bit          chk_st;
        logic [2:0]  fl;
        logic [15:0] tc;
        logic [15:0] nc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic cmp(string n, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, req);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk_br) begin
                    cmp({e.name, ".br_taken"}, {15'd0, br_taken}, {15'd0, e.br});
                    cmp({e.name, ".flush"}, {15'd0, flush}, {15'd0, e.br});
                    cmp({e.name, ".br_target"}, br_target, e.tgt);
                end
                if (e.chk_st) begin
                    cmp({e.name, ".flags_q"}, {13'd0, flags_q}, {13'd0, e.fl});
                    cmp({e.name, ".taken_cnt"}, taken_cnt, e.tc);
                    cmp({e.name, ".nottaken_cnt"}, nottaken_cnt, e.nc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ex_valid = 0; ex_stall = 0; ex_set_z = 0; ex_set_nv = 0;
        ex_zero = 0; ex_neg = 0; ex_ovfl = 0;
        id_br_valid = 0; id_stall = 0; id_br_reg = 0; id_cond = 3'b000;
        id_pc_plus2 = 16'h0; id_imm = 9'h0; id_reg_target = 16'h0;
    endtask

    task automatic br(input logic [2:0] c, input logic [15:0] pc,
                      input logic [8:0] imm);
        id_br_valid = 1; id_br_reg = 0; id_cond = c;
        id_pc_plus2 = pc; id_imm = imm;
    endtask

    task automatic exp_br(string n, logic b, logic [15:0] t);
        exp_t e;
        e = '{name: n, chk_br: 1, br: b, tgt: t, chk_st: 0,
              fl: 3'b0, tc: 16'h0, nc: 16'h0};
        sb.push_back(e);
    endtask

    task automatic exp_st(string n, logic [2:0] f, logic [15:0] tc,
                          logic [15:0] nc);
        exp_t e;
        e = '{name: n, chk_br: 0, br: 1'b0, tgt: 16'h0, chk_st: 1,
              fl: f, tc: tc, nc: nc};
        sb.push_back(e);
    endtask

    initial begin
        rst = 1;
        idle_in();
        step();
        exp_br("rst_idle", 0, 16'h0);
        exp_st("rst_idle", 3'b000, 16'd0, 16'd0);
        step();
        br(3'b111, 16'h0010, 9'h001);
        exp_br("rst_unc", 0, 16'h0);
        step();
        rst = 0;
        idle_in();
        exp_br("post_rst", 0, 16'h0);
        exp_st("post_rst", 3'b000, 16'd0, 16'd0);
        // SUB zero result bypassed into EQ branch
        step();
        ex_valid = 1; ex_set_z = 1; ex_set_nv = 1; ex_zero = 1;
        br(3'b001, 16'h0010, 9'h005);
        exp_br("eq_bypass", 1, 16'h001A);
        step();
        idle_in();
        exp_br("squash1", 0, 16'h0);
        exp_st("after_eq", 3'b100, 16'd1, 16'd0);
        step();
        ex_valid = 1; ex_set_z = 1; ex_zero = 0;
        br(3'b010, 16'h0100, 9'h004);
        exp_br("gt_xor", 1, 16'h0108);
        step();
        idle_in();
        exp_st("after_gt", 3'b000, 16'd2, 16'd0);
        step();
        br(3'b000, 16'h0000, 9'h1FF);
        exp_br("neq_wrap", 1, 16'hFFFE);
        step();
        br(3'b111, 16'h0020, 9'h001);
        exp_br("squash_slot", 0, 16'h0);
        exp_st("squash_slot", 3'b000, 16'd3, 16'd0);
        step();
        idle_in();
        id_br_valid = 1; id_br_reg = 1; id_cond = 3'b111;
        id_reg_target = 16'hBEEA;
        exp_br("unc_reg", 1, 16'hBEEA);
        step();
        exp_br("squash_unc", 0, 16'h0);
        exp_st("squash_unc", 3'b000, 16'd4, 16'd0);
        step();
        idle_in();
        br(3'b001, 16'h0030, 9'h002);
        exp_br("eq_nt", 0, 16'h0);
        exp_st("eq_nt", 3'b000, 16'd4, 16'd0);
        // LT held by ID stall while EX commits N=1
        step();
        br(3'b011, 16'h0040, 9'h1FE);
        id_stall = 1;
        ex_valid = 1; ex_set_nv = 1; ex_neg = 1;
        exp_br("stall0", 0, 16'h0);
        exp_st("stall0", 3'b000, 16'd4, 16'd1);
        step();
        ex_valid = 0; ex_set_nv = 0; ex_neg = 0;
        exp_br("stall1", 0, 16'h0);
        exp_st("stall1", 3'b010, 16'd4, 16'd1);
        step();
        exp_br("stall2", 0, 16'h0);
        step();
        id_stall = 0;
        exp_br("lt_release", 1, 16'h003C);
        step();
        idle_in();
        exp_st("after_lt", 3'b010, 16'd5, 16'd1);
        // Stalled EX still bypasses, but must not commit
        step();
        ex_valid = 1; ex_stall = 1; ex_set_z = 1; ex_zero = 1;
        br(3'b001, 16'h7FFE, 9'h0FF);
        exp_br("exstall_byp", 1, 16'h81FC);
        step();
        idle_in();
        exp_st("exstall_nocommit", 3'b010, 16'd6, 16'd1);
        // Saturate nottaken_cnt with OVFL (V=0)
        step();
        br(3'b110, 16'h0050, 9'h010);
        exp_br("ovfl_nt", 0, 16'h0);
        repeat (65534) step();
        exp_st("nt_max", 3'b010, 16'd6, 16'hFFFF);
        step();
        exp_st("nt_sat", 3'b010, 16'd6, 16'hFFFF);
        idle_in();
        rst = 1;
        br(3'b111, 16'h0060, 9'h001);
        exp_br("rst_late", 0, 16'h0);
        step();
        rst = 0;
        idle_in();
        exp_st("rst_late_st", 3'b000, 16'd0, 16'd0);
        step();
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
